// File: rtl/n_fifo_w16r8_pkg.sv
// Shared constants for the 16-bit-in / 8-bit-out capture FIFO.
package n_fifo_w16r8_pkg;

    localparam int DFLT_WR_DEPTH_WIDTH   = 9;
    localparam int DFLT_WR_DATA_WIDTH    = 16;
    localparam int DFLT_RD_DEPTH_WIDTH   = 10;
    localparam int DFLT_RD_DATA_WIDTH    = 8;
    localparam int DFLT_ALMOST_FULL_NUM  = 255;
    localparam int DFLT_ALMOST_EMPTY_NUM = 900;

    // Bytes per write word; the pointer/level arithmetic assumes exactly 2.
    localparam int RATIO = 2;

endpackage

// File: rtl/n_fifo_w16r8_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module fifo_sdp_ram #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
)(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output only moves on an accepted read, so the consumer sees a held byte.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/n_fifo_w16r8.sv
// Single-clock FIFO, 16-bit words in, bytes out (low byte first).
// Levels are derived from one byte count; flags decode the registered count.
module n_fifo_w16r8
    import n_fifo_w16r8_pkg::*;
#(
    parameter int WR_DEPTH_WIDTH   = DFLT_WR_DEPTH_WIDTH,
    parameter int WR_DATA_WIDTH    = DFLT_WR_DATA_WIDTH,
    parameter int RD_DEPTH_WIDTH   = DFLT_RD_DEPTH_WIDTH,
    parameter int RD_DATA_WIDTH    = DFLT_RD_DATA_WIDTH,
    parameter int ALMOST_FULL_NUM  = DFLT_ALMOST_FULL_NUM,
    parameter int ALMOST_EMPTY_NUM = DFLT_ALMOST_EMPTY_NUM
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    input  logic                     wr_en,
    output logic                     wr_full,
    output logic                     almost_full,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
    input  logic                     rd_en,
    output logic                     rd_empty,
    output logic                     almost_empty
);

    localparam int CNT_W    = RD_DEPTH_WIDTH + 1;
    localparam int WR_LVL_W = WR_DEPTH_WIDTH + 1;
    localparam int WR_DEPTH = 1 << WR_DEPTH_WIDTH;

    logic [WR_DEPTH_WIDTH-1:0] wr_ptr;
    logic [RD_DEPTH_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]          byte_count;
    logic [CNT_W-1:0]          count_next;
    logic [WR_LVL_W-1:0]       wr_level;
    logic                      wr_go;
    logic                      rd_go;
    logic                      byte_sel_q;
    logic                      rd_valid_q;
    logic [WR_DATA_WIDTH-1:0]  ram_q;

    // A half-read word still owns its slot, hence the round-up.
    assign wr_level     = WR_LVL_W'((byte_count + 1'b1) >> 1);

    assign wr_full      = (wr_level == WR_LVL_W'(WR_DEPTH));
    assign almost_full  = (wr_level >= WR_LVL_W'(ALMOST_FULL_NUM));
    assign rd_empty     = (byte_count == '0);
    assign almost_empty = (byte_count <= CNT_W'(ALMOST_EMPTY_NUM));

    assign wr_go = wr_en && !wr_full;
    assign rd_go = rd_en && !rd_empty;

    always_comb begin
        count_next = byte_count;
        case ({wr_go, rd_go})
            2'b10:   count_next = byte_count + CNT_W'(RATIO);
            2'b01:   count_next = byte_count - 1'b1;
            2'b11:   count_next = byte_count + CNT_W'(RATIO - 1);
            default: count_next = byte_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            byte_count <= '0;
            byte_sel_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            byte_count <= count_next;
            if (wr_go) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_go) begin
                rd_ptr     <= rd_ptr + 1'b1;
                byte_sel_q <= rd_ptr[0];
                rd_valid_q <= 1'b1;
            end
        end
    end

    fifo_sdp_ram #(
        .ADDR_WIDTH (WR_DEPTH_WIDTH),
        .DATA_WIDTH (WR_DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_go),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_go),
        .rd_addr (rd_ptr[RD_DEPTH_WIDTH-1:1]),
        .rd_data (ram_q)
    );

    // RAM output is not reset, so the byte is forced to zero until the first read.
    always_comb begin
        rd_data = '0;
        if (rd_valid_q) begin
            rd_data = byte_sel_q ? ram_q[RD_DATA_WIDTH +: RD_DATA_WIDTH]
                                 : ram_q[0 +: RD_DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_n_fifo_w16r8.sv
// Scoreboard bench for n_fifo_w16r8: byte queue plus a byte-count model.
module tb_n_fifo_w16r8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_full;
    logic        almost_full;
    logic [7:0]  rd_data;
    logic        rd_empty;
    logic        almost_empty;

    always #5 clk = ~clk;

    n_fifo_w16r8 dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_full      (wr_full),
        .almost_full  (almost_full),
        .rd_data      (rd_data),
        .rd_en        (rd_en),
        .rd_empty     (rd_empty),
        .almost_empty (almost_empty)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb[$];
    int         m_count = 0;
    logic [7:0] m_rd = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        int wl;
        wl = (m_count + 1) / 2;
        check_val({tag, "/rd_data"},      32'(rd_data),      32'(m_rd));
        check_val({tag, "/rd_empty"},     32'(rd_empty),     32'(m_count == 0));
        check_val({tag, "/almost_empty"}, 32'(almost_empty), 32'(m_count <= 900));
        check_val({tag, "/wr_full"},      32'(wr_full),      32'(wl == 512));
        check_val({tag, "/almost_full"},  32'(almost_full),  32'(wl >= 255));
    endtask

    task automatic cycle(input logic we, input logic [15:0] wd, input logic re, input string tag);
        logic wr_ok;
        logic rd_ok;
        wr_ok   = we && (((m_count + 1) / 2) != 512);
        rd_ok   = re && (m_count != 0);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (rd_ok) begin
            if (sb.size() == 0) begin
                check_val({tag, "/sb_underflow"}, 32'(sb.size()), 32'd1);
            end else begin
                m_rd = sb.pop_front();
            end
            m_count--;
        end
        if (wr_ok) begin
            sb.push_back(wd[7:0]);
            sb.push_back(wd[15:8]);
            m_count += 2;
        end
        check_flags(tag);
    endtask

    task automatic do_reset(input string tag);
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_count = 0;
        m_rd    = 8'h00;
        sb.delete();
        check_flags(tag);
    endtask

    initial begin
        do_reset("reset");
        check_val("reset/rd_data_zero", 32'(rd_data), 32'h00);
        check_val("reset/empty",        32'(rd_empty), 32'd1);

        for (int i = 0; i < 512; i++) begin
            cycle(1'b1, 16'(16'hFFFF - i), 1'b0, "fill");
            if (i == 449) check_val("fill450/almost_empty", 32'(almost_empty), 32'd1);
            if (i == 450) check_val("fill451/almost_empty", 32'(almost_empty), 32'd0);
            if (i == 253) check_val("fill254/almost_full",  32'(almost_full),  32'd0);
            if (i == 254) check_val("fill255/almost_full",  32'(almost_full),  32'd1);
            if (i == 510) check_val("fill511/wr_full",      32'(wr_full),      32'd0);
            if (i == 511) check_val("fill512/wr_full",      32'(wr_full),      32'd1);
        end
        cycle(1'b1, 16'h5555, 1'b0, "fill_over");
        check_val("fill_over/count", 32'(dut.byte_count), 32'd1024);

        for (int i = 0; i < 1025; i++) begin
            cycle(1'b0, 16'h0000, 1'b1, "drain");
            if (i == 0)    check_val("drain1/rd_data",    32'(rd_data),  32'hFF);
            if (i == 0)    check_val("drain1/wr_full",    32'(wr_full),  32'd1);
            if (i == 1)    check_val("drain2/wr_full",    32'(wr_full),  32'd0);
            if (i == 2)    check_val("drain3/rd_data",    32'(rd_data),  32'hFE);
            if (i == 1022) check_val("drain1023/empty",   32'(rd_empty), 32'd0);
            if (i == 1023) check_val("drain1024/empty",   32'(rd_empty), 32'd1);
            if (i == 1024) check_val("drain1025/rd_hold", 32'(rd_data),  32'hFE);
        end

        for (int i = 0; i < 5; i++) cycle(1'b1, 16'($urandom), 1'b0, "sim_pre");
        for (int i = 0; i < 20; i++) cycle(1'b1, 16'($urandom), 1'b1, "sim");
        check_val("sim/count30", 32'(dut.byte_count), 32'd30);

        while (((m_count + 1) / 2) < 510) cycle(1'b1, 16'($urandom), 1'b0, "near_fill");
        for (int i = 0; i < 300; i++) cycle(1'b1, 16'($urandom), 1'b1, "near_sim");
        for (int i = 0; i < 1100 && m_count > 0; i++) cycle(1'b0, 16'h0000, 1'b1, "near_drain");
        check_val("near_drain/empty", 32'(rd_empty), 32'd1);

        cycle(1'b1, 16'h1234, 1'b0, "odd_wr");
        cycle(1'b0, 16'h0000, 1'b1, "odd_rd1");
        check_val("odd_rd1/rd_data",  32'(rd_data),        32'h34);
        check_val("odd_rd1/wr_level", 32'(dut.wr_level),   32'd1);
        check_val("odd_rd1/rd_level", 32'(dut.byte_count), 32'd1);
        cycle(1'b0, 16'h0000, 1'b1, "odd_rd2");
        check_val("odd_rd2/rd_data",  32'(rd_data),  32'h12);
        check_val("odd_rd2/empty",    32'(rd_empty), 32'd1);

        for (int i = 0; i < 100; i++) cycle(1'b1, 16'($urandom), 1'b0, "mid_wr");
        for (int i = 0; i < 50; i++)  cycle(1'b0, 16'h0000, 1'b1, "mid_rd");
        do_reset("mid_reset");
        check_val("mid_reset/empty",        32'(rd_empty),     32'd1);
        check_val("mid_reset/almost_empty", 32'(almost_empty), 32'd1);
        check_val("mid_reset/rd_data",      32'(rd_data),      32'h00);
        cycle(1'b1, 16'hABCD, 1'b0, "post_wr");
        cycle(1'b0, 16'h0000, 1'b1, "post_rd1");
        check_val("post_rd1/rd_data", 32'(rd_data), 32'hCD);
        cycle(1'b0, 16'h0000, 1'b1, "post_rd2");
        check_val("post_rd2/rd_data", 32'(rd_data), 32'hAB);
        check_val("post_rd2/empty",   32'(rd_empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/n_fifo_w16r8.md
Name: n_fifo_w16r8

Overview:
- Single-clock synchronous FIFO with width conversion: 16-bit write words in, 8-bit read bytes out.
- Capacity is 512 words, which equals 1024 bytes.
- Provides full, empty, almost_full and almost_empty flags.
- Sits between a 16-bit sample producer and a byte-wide consumer in the oscilloscope capture path. The global-reset primitive (GTP_GRS) is a device-level cell and is not part of this block.

Parameters:
- WR_DEPTH_WIDTH, 9: log2 of write depth in words (512).
- WR_DATA_WIDTH, 16: write word width.
- RD_DEPTH_WIDTH, 10: log2 of read depth in bytes (1024).
- RD_DATA_WIDTH, 8: read width. WR_DATA_WIDTH/RD_DATA_WIDTH must equal 2.
- ALMOST_FULL_NUM, 255: almost_full threshold, in write words.
- ALMOST_EMPTY_NUM, 900: almost_empty threshold, in read bytes.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous active-high reset.
- wr_data  in  16  write word.
- wr_en  in  1  write request.
- wr_full  out  1  no room for another word.
- almost_full  out  1  write level >= ALMOST_FULL_NUM.
- rd_data  out  8  read byte.
- rd_en  in  1  read request.
- rd_empty  out  1  no bytes stored.
- almost_empty  out  1  read level <= ALMOST_EMPTY_NUM.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- State registers:
  - 9-bit word write pointer.
  - 10-bit byte read pointer.
  - 11-bit byte_count, range 0..1024.
  - Storage: 512x16 simple dual-port RAM.
- Derived levels:
  - rd_level = byte_count.
  - wr_level = (byte_count+1)>>1, i.e. a partially read word still occupies a word slot.
- Flags are combinational decodes of the registered counts, so they reflect the state after each clock edge:
  - wr_full = (wr_level == 512).
  - rd_empty = (byte_count == 0).
  - almost_full = (wr_level >= ALMOST_FULL_NUM).
  - almost_empty = (rd_level <= ALMOST_EMPTY_NUM).
- Write: wr_en && !wr_full stores wr_data at the write pointer, increments the pointer (wraps 511->0) and adds 2 to byte_count. A write while full is ignored with no state change.
- Read: rd_en && !rd_empty increments the read pointer (wraps 1023->0) and subtracts 1 from byte_count. A read while empty is ignored and rd_data holds.
- Byte order: the low byte of each word is read first (little-endian). The byte address is {word_addr, byte_sel}.
- Read latency is 1 cycle. rd_data is registered with no extra output register: the byte appears on the clock edge that accepts the read and holds until the next accepted read.
- Simultaneous write and read: both occur, and byte_count changes by +1. Flags are evaluated on pre-edge state, so there is no fall-through: a write into an empty FIFO is readable from the next cycle.
- Reset (synchronous, any time including mid-transfer):
  - Pointers and byte_count cleared.
  - rd_data = 0x00, rd_empty = 1, almost_empty = 1, wr_full = 0, almost_full = 0.
  - RAM contents are not cleared.

Decomposition:
- Shared package holds the constants:
  - depth and width parameters;
  - ratio = 2;
  - default thresholds 255 and 900.
- One natural sub-module: fifo_sdp_ram, a 512x16 simple dual-port RAM with a synchronous read port. The top level does the byte select and registers rd_data.

Test Plan:
- Reset: after rst, expect rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_data=0x00.
- Fill: write 512 words counting down from 0xFFFF.
  - almost_empty stays 1 through write 450 (900 bytes) and drops after write 451.
  - almost_full rises after write 255.
  - wr_full rises after write 512.
  - A 513th write is ignored (count unchanged).
- Drain: read 1025 times and expect the bytes FF,FF,FE,FF,FD,FF,... one cycle after each rd_en.
  - wr_full drops after the 2nd read.
  - rd_empty rises after read 1024; the 1025th read is ignored and rd_data holds.
- Simultaneous: with 10 bytes stored, assert wr_en and rd_en for 20 cycles. byte_count must reach 30, data order must be preserved, and pointer wrap must be exercised by running near capacity.
- Odd drain: write 0x1234, read 1 byte (0x34). Expect wr_level=1 and rd_level=1. Then read 0x12 and expect rd_empty=1.
- Reset mid-operation: assert rst after 100 writes and 50 reads. Expect empty flags, then write 0xABCD and read 0xCD, 0xAB.
